// File: rtl/dm_ctrl_pkg.sv
// Shared types and default widths for the data-memory arbiter.
package dm_ctrl_pkg;

    localparam int unsigned ADSizeDef = 16;
    localparam int unsigned DASizeDef = 32;

    typedef enum logic {INIT, RUN} state_t;

    typedef struct packed {
        logic                 write;
        logic [ADSizeDef-1:0] addr;
        logic [DASizeDef-1:0] wdata;
    } req_t;

endpackage

// File: rtl/dm_arbiter_if.sv
// Requester handshakes plus the data-memory port, seen from the arbiter (slave)
// or from the requesters/memory side (master).
interface dm_arbiter_if #(
    parameter int unsigned ADSize = 16,
    parameter int unsigned DASize = 32
);

    logic              req0_valid;
    logic              req0_ready;
    logic              req0_write;
    logic [ADSize-1:0] req0_addr;
    logic [DASize-1:0] req0_wdata;
    logic              req0_rvalid;
    logic [DASize-1:0] req0_rdata;

    logic              req1_valid;
    logic              req1_ready;
    logic              req1_write;
    logic [ADSize-1:0] req1_addr;
    logic [DASize-1:0] req1_wdata;
    logic              req1_rvalid;
    logic [DASize-1:0] req1_rdata;

    logic              dm_enable;
    logic              dm_write;
    logic [ADSize-1:0] dm_address;
    logic [DASize-1:0] dm_in;
    logic [DASize-1:0] dm_out;

    modport slave (
        input  req0_valid, req0_write, req0_addr, req0_wdata,
        input  req1_valid, req1_write, req1_addr, req1_wdata,
        input  dm_out,
        output req0_ready, req0_rvalid, req0_rdata,
        output req1_ready, req1_rvalid, req1_rdata,
        output dm_enable, dm_write, dm_address, dm_in
    );

    modport master (
        output req0_valid, req0_write, req0_addr, req0_wdata,
        output req1_valid, req1_write, req1_addr, req1_wdata,
        output dm_out,
        input  req0_ready, req0_rvalid, req0_rdata,
        input  req1_ready, req1_rvalid, req1_rdata,
        input  dm_enable, dm_write, dm_address, dm_in
    );

endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; the pointer names the requester favoured on a tie
// and flips to the other side after every grant.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] valid_i,
    output logic [1:0] grant_o
);

    logic ptr_q;
    logic ptr_d;

    always_comb begin
        if (valid_i == 2'b11) begin
            grant_o = ptr_q ? 2'b10 : 2'b01;
        end else begin
            grant_o = valid_i;
        end
        ptr_d = ptr_q;
        if (grant_o[0]) begin
            ptr_d = 1'b1;
        end else if (grant_o[1]) begin
            ptr_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/dm_arbiter.sv
// Data-memory front end: zeroes the memory after reset, then round-robins two
// single-word requesters onto the one memory port and steers read data back.
module dm_arbiter
    import dm_ctrl_pkg::*;
#(
    parameter int unsigned     ADSize    = ADSizeDef,
    parameter int unsigned     DASize    = DASizeDef,
    parameter logic [ADSize:0] CLR_WORDS = {1'b1, {ADSize{1'b0}}}
) (
    input  logic        clk,
    input  logic        rst_n,
    dm_arbiter_if.slave bus,
    output logic        init_done_o
);

    localparam logic [ADSize:0] CntOne  = (ADSize + 1)'(1);
    localparam logic [ADSize:0] ClrLast = CLR_WORDS - CntOne;
    localparam bit              ClrEn   = (CLR_WORDS != '0);

    state_t          state_q;
    logic [ADSize:0] clr_cnt_q;
    logic [1:0]      tag_q;
    logic            init_done_q;
    logic [1:0]      valid;
    logic [1:0]      grant;
    logic [1:0]      rd_grant;
    req_t            win;

    // Requests are invisible to the arbiter until the clear sweep has finished.
    assign valid = {bus.req1_valid, bus.req0_valid} & {2{state_q == RUN}};

    rr_arb2 u_rr_arb2 (
        .clk     (clk),
        .rst_n   (rst_n),
        .valid_i (valid),
        .grant_o (grant)
    );

    assign bus.req0_ready = grant[0];
    assign bus.req1_ready = grant[1];
    assign rd_grant       = grant & ~{bus.req1_write, bus.req0_write};

    always_comb begin
        win = '0;
        if (grant[1]) begin
            win.write = bus.req1_write;
            win.addr  = ADSizeDef'(bus.req1_addr);
            win.wdata = DASizeDef'(bus.req1_wdata);
        end else if (grant[0]) begin
            win.write = bus.req0_write;
            win.addr  = ADSizeDef'(bus.req0_addr);
            win.wdata = DASizeDef'(bus.req0_wdata);
        end
    end

    always_comb begin
        bus.dm_enable  = 1'b0;
        bus.dm_write   = 1'b0;
        bus.dm_address = '0;
        bus.dm_in      = '0;
        if (state_q == INIT) begin
            bus.dm_enable  = 1'b1;
            bus.dm_write   = 1'b1;
            bus.dm_address = clr_cnt_q[ADSize-1:0];
        end else if (|grant) begin
            bus.dm_enable  = 1'b1;
            bus.dm_write   = win.write;
            bus.dm_address = ADSize'(win.addr);
            bus.dm_in      = DASize'(win.wdata);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ClrEn ? INIT : RUN;
            clr_cnt_q   <= '0;
            tag_q       <= '0;
            init_done_q <= !ClrEn;
        end else begin
            tag_q <= rd_grant;
            if (state_q == INIT) begin
                clr_cnt_q <= clr_cnt_q + CntOne;
                if (clr_cnt_q == ClrLast) begin
                    state_q     <= RUN;
                    init_done_q <= 1'b1;
                end
            end
        end
    end

    // Memory read output is registered, so the tag lines up with dm_out.
    assign bus.req0_rvalid = tag_q[0];
    assign bus.req1_rvalid = tag_q[1];
    assign bus.req0_rdata  = tag_q[0] ? bus.dm_out : '0;
    assign bus.req1_rdata  = tag_q[1] ? bus.dm_out : '0;
    assign init_done_o     = init_done_q;

endmodule

// File: tb/tb_dm_arbiter.sv
// Bench for dm_arbiter: directed steps then random traffic, checked against a
// word-level reference (reference memory, last-winner fairness, one-cycle reads).
module tb_dm_arbiter;
    import dm_ctrl_pkg::*;

    localparam int unsigned AW   = 16;
    localparam int unsigned DW   = 32;
    localparam int          ClrA = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dm_arbiter_if #(.ADSize(AW), .DASize(DW)) bus_a ();
    dm_arbiter_if #(.ADSize(AW), .DASize(DW)) bus_b ();
    logic done_a;
    logic done_b;

    dm_arbiter #(.ADSize(AW), .DASize(DW), .CLR_WORDS(17'd8)) u_dut_a (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus_a),
        .init_done_o (done_a)
    );

    dm_arbiter #(.ADSize(AW), .DASize(DW), .CLR_WORDS(17'd0)) u_dut_b (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus_b),
        .init_done_o (done_b)
    );

    function automatic logic [31:0] init_val(input int a);
        return 32'hA5A5_0000 + 32'(a) * 32'h0000_0101 + 32'h7;
    endfunction

    // Environment: 64-word memory with registered read for each instance.
    logic [DW-1:0] mem_a [64];
    logic [DW-1:0] mem_b [64];
    logic [DW-1:0] dout_a = '0;
    logic [DW-1:0] dout_b = '0;
    logic          env_init = 1'b0;
    int            b_writes = 0;

    always @(posedge clk) begin
        if (!env_init) begin
            for (int i = 0; i < 64; i++) begin
                mem_a[i] <= init_val(i);
                mem_b[i] <= init_val(i);
            end
            env_init <= 1'b1;
        end else begin
            if (bus_a.dm_enable) begin
                if (bus_a.dm_write) mem_a[bus_a.dm_address[5:0]] <= bus_a.dm_in;
                else dout_a <= mem_a[bus_a.dm_address[5:0]];
            end
            if (bus_b.dm_enable) begin
                if (bus_b.dm_write) mem_b[bus_b.dm_address[5:0]] <= bus_b.dm_in;
                else dout_b <= mem_b[bus_b.dm_address[5:0]];
            end
        end
    end

    always @(posedge clk) begin
        if (rst_n && bus_b.dm_enable && bus_b.dm_write) b_writes <= b_writes + 1;
    end

    assign bus_a.dm_out = dout_a;
    assign bus_b.dm_out = dout_b;

    // Reference model state for instance A.
    logic [31:0] ref_mem [64];
    bit          m_init;
    int          m_idx;
    int          favour;
    logic [1:0]  m_rv;
    logic [31:0] m_rd;
    logic [1:0]  m_g;
    logic [1:0]  m_v;
    logic [48:0] m_req;
    int          wait_c [2];

    int n_assert = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [48:0] req_fields(input logic n);
        if (n) return {bus_a.req1_write, bus_a.req1_addr, bus_a.req1_wdata};
        return {bus_a.req0_write, bus_a.req0_addr, bus_a.req0_wdata};
    endfunction

    task automatic drive(input int n, input logic v, input logic w, input logic [15:0] a,
                         input logic [31:0] d);
        if (n == 0) begin
            bus_a.req0_valid = v;
            bus_a.req0_write = w;
            bus_a.req0_addr  = a;
            bus_a.req0_wdata = d;
        end else begin
            bus_a.req1_valid = v;
            bus_a.req1_write = w;
            bus_a.req1_addr  = a;
            bus_a.req1_wdata = d;
        end
    endtask

    task automatic model_reset();
        m_init = 1'b1;
        m_idx  = 0;
        favour = 0;
        m_rv   = 2'b00;
        m_rd   = '0;
        m_g    = 2'b00;
        wait_c[0] = 0;
        wait_c[1] = 0;
    endtask

    // Compare A's outputs for the current cycle against the reference.
    task automatic sample();
        logic [49:0] exp_drv;
        @(negedge clk);
        m_v = {bus_a.req1_valid, bus_a.req0_valid};
        if (m_init) begin
            m_g = 2'b00;
            exp_drv = {1'b1, 1'b1, 16'(m_idx), 32'h0};
            chk("init_done", done_a, 0);
        end else begin
            if (m_v == 2'b11) m_g = (favour == 0) ? 2'b01 : 2'b10;
            else m_g = m_v;
            if (m_g != 2'b00) begin
                m_req   = req_fields(m_g[1]);
                exp_drv = {1'b1, m_req};
            end else begin
                exp_drv = '0;
            end
            chk("init_done", done_a, 1);
        end
        chk("ready", {bus_a.req1_ready, bus_a.req0_ready}, m_g);
        chk("mem_drive", {bus_a.dm_enable, bus_a.dm_write, bus_a.dm_address, bus_a.dm_in},
            exp_drv);
        chk("rvalid", {bus_a.req1_rvalid, bus_a.req0_rvalid}, m_rv);
        chk("rdata0", bus_a.req0_rdata, m_rv[0] ? m_rd : 32'h0);
        chk("rdata1", bus_a.req1_rdata, m_rv[1] ? m_rd : 32'h0);
    endtask

    task automatic advance();
        logic [15:0] a;
        @(posedge clk);
        m_rv = 2'b00;
        if (m_init) begin
            ref_mem[m_idx] = '0;
            m_idx++;
            if (m_idx == ClrA) m_init = 1'b0;
        end else begin
            for (int n = 0; n < 2; n++) begin
                if (m_g[n]) begin
                    chk("starve", wait_c[n] <= 1, 1);
                    wait_c[n] = 0;
                end else if (m_v[n]) begin
                    wait_c[n]++;
                end
            end
            if (m_g != 2'b00) begin
                favour = m_g[1] ? 0 : 1;
                a = m_req[47:32];
                if (m_req[48]) begin
                    ref_mem[a[5:0]] = m_req[31:0];
                end else begin
                    m_rv[m_g[1]] = 1'b1;
                    m_rd         = ref_mem[a[5:0]];
                end
            end
        end
        #1;
    endtask

    logic [1:0] order [4];
    logic       vld;

    initial begin
        order = '{2'b01, 2'b10, 2'b01, 2'b10};
        for (int i = 0; i < 64; i++) ref_mem[i] = init_val(i);
        drive(0, 1'b0, 1'b0, 16'h0, 32'h0);
        drive(1, 1'b0, 1'b0, 16'h0, 32'h0);
        bus_b.req0_valid = 1'b0; bus_b.req0_write = 1'b0;
        bus_b.req0_addr  = '0;   bus_b.req0_wdata = '0;
        bus_b.req1_valid = 1'b0; bus_b.req1_write = 1'b0;
        bus_b.req1_addr  = '0;   bus_b.req1_wdata = '0;
        model_reset();

        // Reset state.
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        chk("rst_ready_a", {bus_a.req1_ready, bus_a.req0_ready}, 2'b00);
        chk("rst_rvalid_a", {bus_a.req1_rvalid, bus_a.req0_rvalid}, 2'b00);
        chk("rst_done_a", done_a, 0);
        chk("rst_done_b", done_b, 1);
        chk("rst_rvalid_b", {bus_b.req1_rvalid, bus_b.req0_rvalid}, 2'b00);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // CLR_WORDS=0 instance is granted in the first cycle.
        bus_b.req1_valid = 1'b1;
        bus_b.req1_addr  = 16'd3;
        sample();
        chk("b_ready", {bus_b.req1_ready, bus_b.req0_ready}, 2'b10);
        chk("b_drive", {bus_b.dm_enable, bus_b.dm_write, bus_b.dm_address}, {2'b10, 16'd3});
        advance();
        bus_b.req1_valid = 1'b0;
        sample();
        chk("b_rvalid", {bus_b.req1_rvalid, bus_b.req0_rvalid}, 2'b10);
        chk("b_rdata1", bus_b.req1_rdata, init_val(3));
        chk("b_idle", bus_b.dm_enable, 0);
        advance();
        for (int k = 0; k < 20 && m_init; k++) begin
            sample();
            advance();
        end
        sample();
        chk("init_done_c8", done_a, 1);
        advance();

        // Preload two words; leaves the tie-break favouring req0.
        drive(0, 1'b1, 1'b1, 16'h0002, 32'h0000_2222);
        sample(); advance();
        drive(0, 1'b0, 1'b0, 16'h0, 32'h0);
        drive(1, 1'b1, 1'b1, 16'h0001, 32'h1111_1111);
        sample(); advance();

        // Contention.
        drive(0, 1'b1, 1'b0, 16'h0001, 32'h0);
        drive(1, 1'b1, 1'b0, 16'h0002, 32'h0);
        for (int i = 0; i < 4; i++) begin
            sample();
            chk("cont_grant", {bus_a.req1_ready, bus_a.req0_ready}, order[i]);
            if (i > 0) begin
                chk("cont_rvalid", {bus_a.req1_rvalid, bus_a.req0_rvalid}, order[i-1]);
                if (order[i-1][0]) chk("cont_rdata0", bus_a.req0_rdata, 32'h1111_1111);
                else chk("cont_rdata1", bus_a.req1_rdata, 32'h0000_2222);
            end
            advance();
        end
        drive(0, 1'b0, 1'b0, 16'h0, 32'h0);
        drive(1, 1'b0, 1'b0, 16'h0, 32'h0);
        sample();
        chk("cont_rdata1_last", bus_a.req1_rdata, 32'h0000_2222);
        advance();

        // Mixed write/read of the same word.
        drive(0, 1'b1, 1'b1, 16'h0005, 32'h1234_5678);
        drive(1, 1'b1, 1'b0, 16'h0005, 32'h0);
        sample();
        chk("mix_first", {bus_a.req1_ready, bus_a.req0_ready}, 2'b01);
        advance();
        drive(0, 1'b0, 1'b0, 16'h0, 32'h0);
        sample(); advance();
        drive(1, 1'b0, 1'b0, 16'h0, 32'h0);
        sample();
        chk("mix_rdata1", bus_a.req1_rdata, 32'h1234_5678);
        advance();

        // Single requester write then read-back.
        drive(0, 1'b1, 1'b1, 16'h0010, 32'hDEAD_BEEF);
        sample(); advance();
        drive(0, 1'b1, 1'b0, 16'h0010, 32'h0);
        sample(); advance();
        drive(0, 1'b0, 1'b0, 16'h0, 32'h0);
        sample();
        chk("single_rvalid", {bus_a.req1_rvalid, bus_a.req0_rvalid}, 2'b01);
        chk("single_rdata0", bus_a.req0_rdata, 32'hDEAD_BEEF);
        advance();

        // Reset right after a read grant.
        drive(0, 1'b1, 1'b0, 16'h0010, 32'h0);
        sample(); advance();
        drive(0, 1'b0, 1'b0, 16'h0, 32'h0);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_rvalid", {bus_a.req1_rvalid, bus_a.req0_rvalid}, 2'b00);
        chk("midrst_drive", {bus_a.dm_enable, bus_a.dm_write, bus_a.dm_address, bus_a.dm_in},
            {2'b11, 48'h0});
        chk("midrst_done", done_a, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        for (int k = 0; k < 20 && m_init; k++) begin
            sample();
            advance();
        end

        // Random traffic; a requester keeps its request until accepted.
        for (int c = 0; c < 400; c++) begin
            for (int n = 0; n < 2; n++) begin
                vld = (n == 0) ? bus_a.req0_valid : bus_a.req1_valid;
                if (!vld || m_g[n]) begin
                    drive(n, $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                          16'($urandom_range(0, 63)), $urandom);
                end
            end
            sample();
            advance();
        end
        drive(0, 1'b0, 1'b0, 16'h0, 32'h0);
        drive(1, 1'b0, 1'b0, 16'h0, 32'h0);
        sample();
        advance();

        chk("b_no_clear_writes", b_writes, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/dm_arbiter.md
# dm_arbiter

Two-port controller in front of the 64Kx32 data memory. It clears the memory word-by-word after reset and then round-robins single-word read/write requests from two requesters (req0 = core load/store, req1 = DMA/debug) onto the one memory port. It routes each one-cycle-delayed read word back to the requester that issued it. It drives the memory's enable, write, address and write-data inputs, and samples its registered read output.

## Interface
Parameters:
- ADSize, 16, address width (word address)
- DASize, 32, data width
- CLR_WORDS, 17'h10000, number of words zeroed after reset, from address 0; 0 disables the clear sweep

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  reset, asynchronous, active-low
- reqN_valid  input  1  request present (N = 0,1)
- reqN_ready  output  1  request accepted this cycle when valid&ready
- reqN_write  input  1  1 = write, 0 = read
- reqN_addr  input  ADSize  word address
- reqN_wdata  input  DASize  write data
- reqN_rvalid  output  1  read data valid for requester N
- reqN_rdata  output  DASize  read data
- dm_enable  output  1  memory enable
- dm_write  output  1  memory write (1) / read (0)
- dm_address  output  ADSize  memory address
- dm_in  output  DASize  memory write data
- dm_out  input  DASize  memory registered read data
- init_done  output  1  clear sweep finished, requests accepted

## Operation
- FSM states: INIT, RUN.
- Reset entry: INIT if CLR_WORDS>0, else RUN.
- Reset values: clr_cnt=0, priority pointer=0 (req0 favoured), pending-read tags cleared, init_done=0 (1 if CLR_WORDS==0), reqN_rvalid=0, reqN_ready=0.
- INIT: dm_enable=1, dm_write=1, dm_address=clr_cnt[ADSize-1:0], dm_in=0. Both readies are 0.
  - clr_cnt is ADSize+1 bits and increments every cycle.
  - The cycle with clr_cnt==CLR_WORDS-1 is the last write. On the next edge the FSM moves to RUN and init_done goes to 1.
- RUN, arbitration:
  - If only one valid is high, that requester wins.
  - If both are high, the requester named by the pointer wins. After the grant the pointer moves to the other requester.
  - The pointer changes only on a grant.
  - ready is high only for the winner and is combinational from the valids and the pointer.
- RUN, memory drive when a grant occurs: dm_enable=1, dm_write=winner's write bit, dm_address=winner's addr, dm_in=winner's wdata.
- RUN, no grant: dm_enable=0, dm_write=0, dm_address=0, dm_in=0.
- Read return:
  - A granted read registers a one-hot tag for the winner.
  - In the next cycle, that requester's rvalid=1 and its rdata=dm_out, passed through combinationally.
  - Non-tagged rdata is 0.
- Writes produce no response.
- One access per cycle. Back-to-back reads give back-to-back rvalids, each one cycle after its grant.
- Reset mid-operation: the clear sweep restarts from address 0 and any pending rvalid is dropped.
- A requester holds valid and all request fields stable until ready.

## Timing
- Request-to-grant: 0 cycles when the requester wins, combinational ready.
- Read latency: rvalid exactly 1 cycle after the accept cycle.
- Write completion: committed at the accept-cycle edge. A read of the same address granted in the next cycle returns the new data.
- Clear sweep: CLR_WORDS cycles after rst deasserts. The first grant is possible in cycle CLR_WORDS.
- Starvation bound: a valid requester is granted within 2 cycles in RUN.

## Structure
- Package dm_ctrl_pkg holds:
  - typedef enum state_t {INIT, RUN}
  - default ADSize/DASize constants
  - a request struct (write, addr, wdata)
- Sub-module rr_arb2: 2-way round-robin arbiter.
  - Inputs: clk, rst, valid[1:0].
  - Outputs: grant[1:0], one-hot or zero.
  - The pointer register lives inside it.
- All other logic (FSM, clear counter, tag register, muxes) lives in dm_arbiter.

## Test plan
- Reset with CLR_WORDS=8:
  - Cycles 0..7: dm_write=1, dm_in=0, addresses 0..7, both readies 0.
  - Cycle 8: init_done=1.
- Single requester: req0 writes 0xDEADBEEF to 0x0010, then reads 0x0010 in the next cycle → req0_rvalid=1 one cycle later with rdata=0xDEADBEEF, req1_rvalid=0.
- Contention: both valid for 4 cycles, reads of 0x0001 (req0) and 0x0002 (req1) → grant order req0, req1, req0, req1. Each rvalid lands on the matching port with the correct word.
- Mixed: req0 writes 0x0005=0x12345678 while req1 reads 0x0005 in the same cycle → req0 granted first. req1's read in the next cycle returns 0x12345678.
- Reset mid-read: assert rst in the cycle after a read grant → rvalid=0, sweep restarts at address 0.
- CLR_WORDS=0: init_done=1 and a request is granted in the first cycle after reset; no clear writes issued.
